// File: rtl/ofs_plat_reset_release_seq.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_reset_release_seq
// Purpose  : Fans one reset source out to NUM_OUTPUTS active-low resets that
//            are held for a minimum time and then released in index order.
// Revision : 1.0  initial release
// ============================================================================
module ofs_plat_reset_release_seq #(
    parameter int NUM_OUTPUTS       = 4,
    parameter int MIN_ASSERT_CYCLES = 16,
    parameter int STAGE_DELAY       = 8,
    parameter int READY_TIMEOUT     = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   soft_reset_req,
    input  logic [NUM_OUTPUTS-1:0] stage_ready,
    output logic [NUM_OUTPUTS-1:0] reset_n_out,
    output logic                   all_released,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int c_max_ab  = (MIN_ASSERT_CYCLES > STAGE_DELAY) ? MIN_ASSERT_CYCLES : STAGE_DELAY;
    localparam int c_max_val = (c_max_ab > READY_TIMEOUT) ? c_max_ab : READY_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_max_val + 1);
    localparam int c_idx_w   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_sat  = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w:0]     c_one_ext  = (c_cnt_w + 1)'(1);
    localparam logic [c_cnt_w:0]     c_min      = (c_cnt_w + 1)'(MIN_ASSERT_CYCLES);
    localparam logic [c_cnt_w:0]     c_delay    = (c_cnt_w + 1)'(STAGE_DELAY);
    localparam logic [c_cnt_w:0]     c_tmo      = (c_cnt_w + 1)'(READY_TIMEOUT);
    localparam logic [c_idx_w:0]     c_idx_one  = (c_idx_w + 1)'(1);
    localparam logic [c_idx_w:0]     c_last_idx = (c_idx_w + 1)'(NUM_OUTPUTS - 1);
    localparam logic [NUM_OUTPUTS-1:0] c_bit0   = NUM_OUTPUTS'(1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state, w_state;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt;
    logic [c_idx_w-1:0]     r_idx, w_idx;
    logic [NUM_OUTPUTS-1:0] r_rst_n, w_rst_n;
    logic                   r_all, w_all;
    logic                   r_busy, w_busy;
    logic                   r_err, w_err;

    logic                   w_source;
    logic [c_cnt_w-1:0]     w_cnt_inc;
    logic [c_cnt_w:0]       w_elapsed;
    logic [c_idx_w:0]       w_idx_inc;
    logic                   w_ready_ok;
    logic                   w_to;

    assign w_source  = reset | soft_reset_req;
    assign w_cnt_inc = (r_cnt == c_cnt_sat) ? r_cnt : (r_cnt + c_cnt_one);
    // In WAIT, r_cnt holds (edges since the last release) - 1 at the sampling edge.
    assign w_elapsed = {1'b0, r_cnt} + c_one_ext;
    assign w_idx_inc = {1'b0, r_idx} + c_idx_one;
    assign w_ready_ok = (w_elapsed >= c_delay) && stage_ready[r_idx];
    assign w_to       = (READY_TIMEOUT != 0) && (w_elapsed >= c_tmo);

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_rst_n = r_rst_n;
        w_err   = r_err;

        if (w_source) begin
            w_state = S_HOLD;
            w_cnt   = '0;
            w_idx   = '0;
            w_rst_n = '0;
            if (reset) begin
                w_err = 1'b0;
            end
        end else begin
            case (r_state)
                S_HOLD: begin
                    if ({1'b0, r_cnt} >= c_min) begin
                        w_rst_n = c_bit0;
                        w_cnt   = '0;
                        w_idx   = '0;
                        w_state = (NUM_OUTPUTS == 1) ? S_DONE : S_WAIT;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                S_WAIT: begin
                    if (w_ready_ok || w_to) begin
                        w_rst_n = r_rst_n | (c_bit0 << w_idx_inc);
                        w_cnt   = '0;
                        w_idx   = w_idx_inc[c_idx_w-1:0];
                        if (!w_ready_ok) begin
                            w_err = 1'b1;
                        end
                        if (w_idx_inc == c_last_idx) begin
                            w_state = S_DONE;
                        end
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                S_DONE: begin
                    w_state = S_DONE;
                end
                default: begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_rst_n = '0;
                end
            endcase
        end

        // Status flags are computed from next-state values so they move on the release edge.
        w_all  = &w_rst_n;
        w_busy = (w_state != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_all   <= 1'b0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_rst_n <= w_rst_n;
            r_all   <= w_all;
            r_busy  <= w_busy;
            r_err   <= w_err;
        end
    end

    assign reset_n_out  = r_rst_n;
    assign all_released = r_all;
    assign busy         = r_busy;
    assign err_timeout  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ofs_plat_reset_release_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofs_plat_reset_release_seq
// Purpose  : Scoreboard bench; expected output changes are queued with the edge
//            at which they must appear and checked by independent monitors.
// Revision : 1.0  initial release
// ============================================================================
module tb_ofs_plat_reset_release_seq;

    logic clk = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Config A: 3 outputs, MIN_ASSERT=4, STAGE_DELAY=2, READY_TIMEOUT=10
    logic       reset_a = 1'b1;
    logic       soft_a  = 1'b0;
    logic [2:0] ready_a = 3'b111;
    logic [2:0] rn_a;
    logic       all_a, busy_a, err_a;

    // Config B: single output, MIN_ASSERT=1, STAGE_DELAY=1, timeout disabled
    logic       reset_b = 1'b1;
    logic       soft_b  = 1'b0;
    logic [0:0] ready_b = 1'b0;
    logic [0:0] rn_b;
    logic       all_b, busy_b, err_b;

    ofs_plat_reset_release_seq #(
        .NUM_OUTPUTS(3), .MIN_ASSERT_CYCLES(4), .STAGE_DELAY(2), .READY_TIMEOUT(10)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .soft_reset_req(soft_a), .stage_ready(ready_a),
        .reset_n_out(rn_a), .all_released(all_a), .busy(busy_a), .err_timeout(err_a)
    );

    ofs_plat_reset_release_seq #(
        .NUM_OUTPUTS(1), .MIN_ASSERT_CYCLES(1), .STAGE_DELAY(1), .READY_TIMEOUT(0)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .soft_reset_req(soft_b), .stage_ready(ready_b),
        .reset_n_out(rn_b), .all_released(all_b), .busy(busy_b), .err_timeout(err_b)
    );

    // Vector layout: {reset_n_out (zero-extended to 3), all_released, busy, err_timeout}
    typedef struct packed {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    function automatic void exp_a(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        qa.push_back(e);
    endfunction

    function automatic void exp_b(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        qb.push_back(e);
    endfunction

    task automatic go_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Monitors: every change of the output vector must match the next queued expectation.
    logic [5:0] prev_a = 6'bxxxxxx;
    logic [5:0] cur_a;
    exp_t       e_a;
    always @(negedge clk) begin
        cur_a = {rn_a, all_a, busy_a, err_a};
        if (cur_a !== prev_a) begin
            compared++;
            if (qa.size() == 0) begin
                mismatched++;
                $display("FAIL dut_a unexpected_change edge %0d: got %b, expected no change", cyc, cur_a);
            end else begin
                e_a = qa.pop_front();
                if (e_a.cyc != cyc || cur_a !== e_a.v) begin
                    mismatched++;
                    $display("FAIL dut_a change: got %b at edge %0d, expected %b at edge %0d",
                             cur_a, cyc, e_a.v, e_a.cyc);
                end
            end
            prev_a = cur_a;
        end
    end

    logic [5:0] prev_b = 6'bxxxxxx;
    logic [5:0] cur_b;
    exp_t       e_b;
    always @(negedge clk) begin
        cur_b = {2'b00, rn_b, all_b, busy_b, err_b};
        if (cur_b !== prev_b) begin
            compared++;
            if (qb.size() == 0) begin
                mismatched++;
                $display("FAIL dut_b unexpected_change edge %0d: got %b, expected no change", cyc, cur_b);
            end else begin
                e_b = qb.pop_front();
                if (e_b.cyc != cyc || cur_b !== e_b.v) begin
                    mismatched++;
                    $display("FAIL dut_b change: got %b at edge %0d, expected %b at edge %0d",
                             cur_b, cyc, e_b.v, e_b.cyc);
                end
            end
            prev_b = cur_b;
        end
    end

    initial begin
        fork
            begin
                // Reset state, then nominal release (t0 = 6)
                exp_a(1, 6'b000010);
                go_to(5);  reset_a = 1'b0;
                exp_a(10, 6'b001010); exp_a(12, 6'b011010); exp_a(14, 6'b111100);
                // Late ready on stage 0 (t0 = 22, ready sampled at 31)
                go_to(20); reset_a = 1'b1; ready_a = 3'b110;
                exp_a(21, 6'b000010);
                go_to(21); reset_a = 1'b0;
                exp_a(26, 6'b001010);
                go_to(30); ready_a = 3'b111;
                exp_a(31, 6'b011010); exp_a(33, 6'b111100);
                // Timeout (t0 = 42), error kept through soft reset
                go_to(40); reset_a = 1'b1; ready_a = 3'b110;
                exp_a(41, 6'b000010);
                go_to(41); reset_a = 1'b0;
                exp_a(46, 6'b001010); exp_a(56, 6'b011011); exp_a(58, 6'b111101);
                go_to(62); soft_a = 1'b1;
                exp_a(63, 6'b000011);
                go_to(63); soft_a = 1'b0; ready_a = 3'b111;
                exp_a(68, 6'b001011); exp_a(70, 6'b011011); exp_a(72, 6'b111101);
                // Reset and soft request together in DONE: error clears
                go_to(76); reset_a = 1'b1; soft_a = 1'b1;
                exp_a(77, 6'b000010);
                // Mid-sequence soft reset (t0 = 78, request at t0+7)
                go_to(77); reset_a = 1'b0; soft_a = 1'b0;
                exp_a(82, 6'b001010); exp_a(84, 6'b011010);
                go_to(84); soft_a = 1'b1;
                exp_a(85, 6'b000010);
                go_to(85); soft_a = 1'b0;
                exp_a(90, 6'b001010); exp_a(92, 6'b011010); exp_a(94, 6'b111100);
                // stage_ready must have no effect in DONE
                go_to(96); ready_a = 3'b000;
                go_to(98); ready_a = 3'b111;
            end
            begin
                // Single-output boundary (t0 = 4, then soft rerun with t0 = 12)
                exp_b(1, 6'b000010);
                go_to(3);  reset_b = 1'b0;
                exp_b(5, 6'b001100);
                go_to(7);  ready_b = 1'b1;
                go_to(10); soft_b = 1'b1;
                exp_b(11, 6'b000010);
                go_to(11); soft_b = 1'b0; ready_b = 1'b0;
                exp_b(13, 6'b001100);
                go_to(16); ready_b = 1'b1;
            end
        join

        go_to(100);
        @(negedge clk);
        while (qa.size() != 0) begin
            e_a = qa.pop_front();
            compared++;
            mismatched++;
            $display("FAIL dut_a missing_change: got no change, expected %b at edge %0d", e_a.v, e_a.cyc);
        end
        while (qb.size() != 0) begin
            e_b = qb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL dut_b missing_change: got no change, expected %b at edge %0d", e_b.v, e_b.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
